bcd_field_editor: RTL and testbench

- Parametrised successor to the chrono/clock time-setting editor.
- Holds N_FIELDS two-digit BCD fields, e.g. HH:MM:SS, and steps a digit cursor with BTl/BTr. BTup/BTdown change the digit under the cursor, with per-field maximum limits.
- Adds auto-repeat on a held up/down button, a single-cycle update path, preload from the running counter, and a commit pulse when editing ends.
- Sits between the debounced button block and the chrono/clock counters.

---
 rtl/bcd_pkg.sv | 16 +
 rtl/btn_repeat.sv | 63 ++++++
 rtl/bcd_field_editor.sv | 135 +++++++++++++
 tb/tb_bcd_field_editor.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types, defaults and digit-limit helper for the BCD field editor.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam logic [23:0] DEF_MAX_HMS = 24'h235959;
  localparam logic [23:0] DEF_INIT    = 24'h000001;

  // Largest legal units digit given the current tens digit and the field limits.
  function automatic bcd_digit_t field_umax(input bcd_digit_t t,
                                            input bcd_digit_t mt,
                                            input bcd_digit_t mu);
    return (t == mt) ? mu : 4'd9;
  endfunction

endpackage

// File: rtl/btn_repeat.sv
// Edge detector plus auto-repeat tick generator for one up/down button.
// step is high for the press edge and for every repeat tick while the button
// is held alone with edit mode enabled.
module btn_repeat #(
  parameter int REPEAT_DLY = 50_000_000,
  parameter int REPEAT_PER = 10_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic btn,
  input  logic other,
  output logic step
);

  localparam int LIM = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int RW  = $clog2(LIM + 1);

  logic          prev;
  logic          armed;   // counting since a valid press edge
  logic          fast;    // first delay elapsed, now on the repeat period
  logic [RW-1:0] cnt;     // cycles since the press edge or last tick

  logic          edge_s;
  logic          hold;
  logic          tick;
  logic [RW-1:0] limit;

  assign edge_s = en & btn & ~prev;
  assign hold   = en & btn & ~other;
  assign limit  = fast ? RW'(REPEAT_PER) : RW'(REPEAT_DLY);
  assign tick   = armed & hold & ~edge_s & (cnt == limit);
  assign step   = edge_s | tick;

  // Track the button level and run the repeat counter while it is held alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev  <= 1'b0;
      armed <= 1'b0;
      fast  <= 1'b0;
      cnt   <= '0;
    end else begin
      prev <= btn;
      if (!hold) begin
        armed <= 1'b0;
        fast  <= 1'b0;
        cnt   <= '0;
      end else if (edge_s) begin
        armed <= 1'b1;
        fast  <= 1'b0;
        cnt   <= RW'(1);
      end else if (armed) begin
        if (tick) begin
          fast <= 1'b1;
          cnt  <= RW'(1);
        end else begin
          cnt <= cnt + RW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/bcd_field_editor.sv
// Multi-field two-digit BCD editor: cursor over digits, per-field limits,
// auto-repeat on up/down, preload, and a commit pulse when editing ends.
module bcd_field_editor
  import bcd_pkg::*;
#(
  parameter int                  N_FIELDS   = 3,
  parameter logic [8*N_FIELDS-1:0] MAX_VALUE  = DEF_MAX_HMS,
  parameter logic [8*N_FIELDS-1:0] INIT_VALUE = DEF_INIT,
  parameter int                  REPEAT_DLY = 50_000_000,
  parameter int                  REPEAT_PER = 10_000_000,
  localparam int                 CW         = $clog2(2*N_FIELDS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  EN,
  input  logic                  BTup,
  input  logic                  BTdown,
  input  logic                  BTl,
  input  logic                  BTr,
  input  logic                  load,
  input  logic [8*N_FIELDS-1:0] load_value,
  output logic [8*N_FIELDS-1:0] value,
  output logic [CW-1:0]         contador,
  output logic                  commit,
  output logic                  dirty
);

  localparam logic [CW-1:0] LAST = CW'(2*N_FIELDS - 1);

  logic step_up, step_dn;
  logic do_up, do_dn;
  logic l_prev, r_prev, en_prev;
  logic l_edge, r_edge, en_fall;

  logic [CW-1:0]         sel_field;
  logic [7:0]            cur_byte, max_byte, new_byte;
  bcd_digit_t            t, u, mt, mu, um, nt, nu;
  logic [8*N_FIELDS-1:0] next_value;
  logic                  value_change;

  btn_repeat #(.REPEAT_DLY(REPEAT_DLY), .REPEAT_PER(REPEAT_PER)) u_rep_up (
    .clk(clk), .reset(reset), .en(EN), .btn(BTup), .other(BTdown), .step(step_up)
  );

  btn_repeat #(.REPEAT_DLY(REPEAT_DLY), .REPEAT_PER(REPEAT_PER)) u_rep_dn (
    .clk(clk), .reset(reset), .en(EN), .btn(BTdown), .other(BTup), .step(step_dn)
  );

  assign do_up     = step_up & ~step_dn;
  assign do_dn     = step_dn & ~step_up;
  assign l_edge    = EN & BTl & ~l_prev;
  assign r_edge    = EN & BTr & ~r_prev;
  assign en_fall   = en_prev & ~EN;
  assign sel_field = contador >> 1;

  // Read-modify-write of the byte under the cursor; contador[0] picks units.
  always_comb begin
    cur_byte = '0;
    max_byte = '0;
    for (int i = 0; i < N_FIELDS; i++) begin
      if (sel_field == CW'(i)) begin
        cur_byte = value[8*(N_FIELDS-1-i) +: 8];
        max_byte = MAX_VALUE[8*(N_FIELDS-1-i) +: 8];
      end
    end
    t  = cur_byte[7:4];
    u  = cur_byte[3:0];
    mt = max_byte[7:4];
    mu = max_byte[3:0];
    um = field_umax(t, mt, mu);
    nt = t;
    nu = u;
    if (do_up || do_dn) begin
      if (!contador[0]) begin
        if (do_up) nt = (t == mt) ? 4'd0 : t + 4'd1;
        else       nt = (t == 4'd0) ? mt : t - 4'd1;
        if ((nt == mt) && (u > mu)) nu = mu;
      end else begin
        if (do_up) nu = (u == um) ? 4'd0 : u + 4'd1;
        else       nu = (u == 4'd0) ? um : u - 4'd1;
      end
    end
    new_byte   = {nt, nu};
    next_value = value;
    for (int i = 0; i < N_FIELDS; i++) begin
      if (sel_field == CW'(i)) next_value[8*(N_FIELDS-1-i) +: 8] = new_byte;
    end
    value_change = (next_value != value);
  end

  // Button/enable history and the one-cycle commit pulse on EN falling.
  always_ff @(posedge clk) begin
    if (reset) begin
      l_prev  <= 1'b0;
      r_prev  <= 1'b0;
      en_prev <= 1'b0;
      commit  <= 1'b0;
    end else begin
      l_prev  <= BTl;
      r_prev  <= BTr;
      en_prev <= EN;
      commit  <= en_fall;
    end
  end

  // Value and dirty flag: load wins over edits, commit clears dirty.
  always_ff @(posedge clk) begin
    if (reset) begin
      value <= INIT_VALUE;
      dirty <= 1'b0;
    end else begin
      if (load) begin
        value <= load_value;
        dirty <= 1'b0;
      end else if (value_change) begin
        value <= next_value;
        dirty <= 1'b1;
      end
      if (en_fall) dirty <= 1'b0;
    end
  end

  // Cursor: parked at 0 outside edit mode, wraps across all digits.
  always_ff @(posedge clk) begin
    if (reset) begin
      contador <= '0;
    end else if (!EN) begin
      contador <= '0;
    end else if (!load && (l_edge ^ r_edge)) begin
      if (r_edge) contador <= (contador == LAST) ? '0 : contador + CW'(1);
      else        contador <= (contador == '0) ? LAST : contador - CW'(1);
    end
  end

endmodule

// File: tb/tb_bcd_field_editor.sv
// Bench for bcd_field_editor: directed vector table, then random stimulus
// against a digit-array reference model.
module tb_bcd_field_editor;

  localparam int DLY = 8;
  localparam int PER = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        EN = 1'b0, BTup = 1'b0, BTdown = 1'b0, BTl = 1'b0, BTr = 1'b0, load = 1'b0;
  logic [23:0] load_value = '0;
  logic [23:0] value;
  logic [2:0]  contador;
  logic        commit, dirty;

  int n_vec = 0;
  int n_bad = 0;

  bcd_field_editor #(
    .N_FIELDS(3), .MAX_VALUE(24'h235959), .INIT_VALUE(24'h000001),
    .REPEAT_DLY(DLY), .REPEAT_PER(PER)
  ) dut (
    .clk(clk), .reset(reset), .EN(EN), .BTup(BTup), .BTdown(BTdown),
    .BTl(BTl), .BTr(BTr), .load(load), .load_value(load_value),
    .value(value), .contador(contador), .commit(commit), .dirty(dirty)
  );

  // clock
  always #5 clk = ~clk;

  typedef struct {
    logic        rst, en, up, dn, l, r, ld;
    logic [23:0] ldv;
    logic [23:0] ev;
    logic [2:0]  ec;
    logic        ecm, ed;
  } vec_t;

  vec_t        vecs[$];
  logic [28:0] exp_q[$];

  function automatic void add(input logic rst, en, up, dn, l, r, ld,
                              input logic [23:0] ldv, input logic [23:0] ev,
                              input int ec, input logic ecm, ed);
    vec_t v;
    v.rst = rst; v.en = en; v.up = up; v.dn = dn; v.l = l; v.r = r; v.ld = ld;
    v.ldv = ldv; v.ev = ev; v.ec = 3'(ec); v.ecm = ecm; v.ed = ed;
    vecs.push_back(v);
  endfunction

  // One button cycle in edit mode followed by a release cycle with the same result.
  function automatic void pulse(input logic up, dn, l, r, input logic [23:0] ev,
                                input int ec, input logic ed);
    add(0, 1, up, dn, l, r, 0, 24'h0, ev, ec, 0, ed);
    add(0, 1, 0, 0, 0, 0, 0, 24'h0, ev, ec, 0, ed);
  endfunction

  task automatic drive(input logic rst, en, up, dn, l, r, ld, input logic [23:0] ldv);
    @(negedge clk);
    reset = rst; EN = en; BTup = up; BTdown = dn; BTl = l; BTr = r;
    load = ld; load_value = ldv;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int idx, input logic [23:0] ev,
                       input logic [2:0] ec, input logic ecm, ed);
    n_vec++;
    if (value !== ev || contador !== ec || commit !== ecm || dirty !== ed) begin
      n_bad++;
      $display("FAIL %s[%0d]: got value=%h contador=%0d commit=%b dirty=%b, want value=%h contador=%0d commit=%b dirty=%b",
               name, idx, value, contador, commit, dirty, ev, ec, ecm, ed);
    end
  endtask

  // ---------------- reference model ----------------
  int   m_dig[6];
  int   m_max[6];
  int   m_cur;
  logic m_prev[4];   // up, dn, l, r
  logic m_en_prev, m_commit, m_dirty;
  logic m_run[2];
  int   m_age[2];

  function automatic logic [23:0] m_value();
    logic [23:0] v;
    v = '0;
    for (int i = 0; i < 6; i++) v[23-4*i -: 4] = 4'(m_dig[i]);
    return v;
  endfunction

  task automatic model_cycle(input logic rst, en, up, dn, l, r, ld, input logic [23:0] ldv);
    logic stp[2];
    logic bs, other, edge_b, l_e, r_e;
    int   f, tt, uu, mt, mu, um;
    if (rst) begin
      for (int i = 0; i < 6; i++) m_dig[i] = (i == 5) ? 1 : 0;
      m_cur = 0; m_en_prev = 0; m_commit = 0; m_dirty = 0;
      for (int i = 0; i < 4; i++) m_prev[i] = 0;
      for (int b = 0; b < 2; b++) begin m_run[b] = 0; m_age[b] = 0; end
      return;
    end
    for (int b = 0; b < 2; b++) begin
      bs     = (b == 0) ? up : dn;
      other  = (b == 0) ? dn : up;
      edge_b = en & bs & !m_prev[b];
      stp[b] = edge_b;
      if (en && bs && !other) begin
        if (edge_b) begin
          m_run[b] = 1; m_age[b] = 0;
        end else if (m_run[b]) begin
          m_age[b]++;
          if (m_age[b] == DLY || (m_age[b] > DLY && (m_age[b] - DLY) % PER == 0)) stp[b] = 1;
        end
      end else begin
        m_run[b] = 0;
      end
    end
    if (ld) begin
      for (int i = 0; i < 6; i++) m_dig[i] = int'(ldv[23-4*i -: 4]);
      m_dirty = 0;
    end else if (stp[0] != stp[1]) begin
      f  = m_cur / 2;
      tt = m_dig[2*f]; uu = m_dig[2*f+1];
      mt = m_max[2*f]; mu = m_max[2*f+1];
      if (m_cur % 2 == 0) begin
        if (stp[0]) tt = (tt == mt) ? 0 : tt + 1;
        else        tt = (tt == 0) ? mt : tt - 1;
        if (tt == mt && uu > mu) uu = mu;
      end else begin
        um = (tt == mt) ? mu : 9;
        if (stp[0]) uu = (uu == um) ? 0 : uu + 1;
        else        uu = (uu == 0) ? um : uu - 1;
      end
      if (tt != m_dig[2*f] || uu != m_dig[2*f+1]) m_dirty = 1;
      m_dig[2*f] = tt; m_dig[2*f+1] = uu;
    end
    m_commit = m_en_prev & !en;
    if (m_commit) m_dirty = 0;
    l_e = en & l & !m_prev[2];
    r_e = en & r & !m_prev[3];
    if (!en) m_cur = 0;
    else if (!ld && (l_e != r_e)) m_cur = r_e ? (m_cur + 1) % 6 : (m_cur + 5) % 6;
    m_prev[0] = up; m_prev[1] = dn; m_prev[2] = l; m_prev[3] = r;
    m_en_prev = en;
  endtask

  function automatic logic [23:0] rand_valid();
    logic [23:0] v;
    int tt, um;
    v = '0;
    for (int fi = 0; fi < 3; fi++) begin
      tt = $urandom_range(0, m_max[2*fi]);
      um = (tt == m_max[2*fi]) ? m_max[2*fi+1] : 9;
      v[23-8*fi -: 4] = 4'(tt);
      v[19-8*fi -: 4] = 4'($urandom_range(0, um));
    end
    return v;
  endfunction

  initial begin
    logic [23:0] maxv;
    logic [28:0] e;
    logic r_en, r_up, r_dn, r_l, r_r, r_ld, r_rst;
    logic [23:0] r_ldv;
    int cnt;

    maxv = 24'h235959;
    for (int i = 0; i < 6; i++) m_max[i] = int'(maxv[23-4*i -: 4]);

    // ---------------- directed table ----------------
    add(1, 1, 0, 0, 0, 0, 0, 24'h0, 24'h000001, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 24'h0, 24'h000001, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 1, 24'h190000, 24'h190000, 0, 0, 0);
    pulse(1, 0, 0, 0, 24'h230000, 0, 1);   // tens up, units clamp 9 -> 3
    pulse(1, 0, 0, 0, 24'h030000, 0, 1);   // tens wrap at Mt
    pulse(1, 0, 0, 0, 24'h130000, 0, 1);
    pulse(1, 0, 0, 0, 24'h230000, 0, 1);
    pulse(0, 1, 0, 0, 24'h130000, 0, 1);
    pulse(0, 1, 0, 0, 24'h030000, 0, 1);
    pulse(0, 1, 0, 0, 24'h230000, 0, 1);   // tens down wraps 0 -> Mt
    pulse(0, 0, 0, 1, 24'h230000, 1, 1);
    pulse(1, 0, 0, 0, 24'h200000, 1, 1);   // units wrap at 3 under tens 2
    pulse(0, 1, 0, 0, 24'h230000, 1, 1);
    pulse(1, 1, 0, 0, 24'h230000, 1, 1);   // up+down together: no change
    add(0, 1, 0, 0, 0, 0, 1, 24'h190000, 24'h190000, 1, 0, 0);
    pulse(1, 0, 0, 0, 24'h100000, 1, 1);   // units 9 -> 0 under tens 1
    pulse(0, 1, 0, 0, 24'h190000, 1, 1);
    pulse(1, 0, 0, 1, 24'h100000, 2, 1);   // edit at old cursor, then move
    pulse(0, 1, 0, 0, 24'h105000, 2, 1);   // minute tens 0 -> 5
    pulse(1, 0, 0, 0, 24'h100000, 2, 1);
    pulse(0, 0, 1, 0, 24'h100000, 1, 1);
    pulse(0, 0, 1, 0, 24'h100000, 0, 1);
    pulse(0, 0, 1, 0, 24'h100000, 5, 1);   // left wraps 0 -> 5
    pulse(0, 0, 1, 1, 24'h100000, 5, 1);   // l+r together: no move
    pulse(0, 0, 0, 1, 24'h100000, 0, 1);   // right wraps 5 -> 0
    pulse(0, 0, 1, 0, 24'h100000, 5, 1);
    pulse(0, 0, 1, 0, 24'h100000, 4, 1);
    pulse(0, 0, 1, 0, 24'h100000, 3, 1);
    add(0, 1, 0, 0, 0, 0, 1, 24'h000000, 24'h000000, 3, 0, 0);
    for (int k = 0; k < 20; k++) begin     // auto-repeat on held up
      cnt = 1 + ((k >= 8) ? 1 : 0) + ((k >= 12) ? 1 : 0) + ((k >= 16) ? 1 : 0);
      add(0, 1, 1, 0, 0, 0, 0, 24'h0, 24'(cnt) << 8, 3, 0, 1);
    end
    add(0, 1, 0, 0, 0, 0, 0, 24'h0, 24'h000400, 3, 0, 1);
    add(0, 1, 0, 0, 0, 0, 0, 24'h0, 24'h000400, 3, 0, 1);
    add(0, 1, 0, 0, 0, 0, 1, 24'h123456, 24'h123456, 3, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 24'h0, 24'h123456, 0, 1, 0);   // commit pulse
    add(0, 0, 0, 0, 0, 0, 0, 24'h0, 24'h123456, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0, 24'h0, 24'h123456, 0, 0, 0);   // ignored with EN=0
    add(0, 0, 0, 0, 0, 0, 0, 24'h0, 24'h123456, 0, 0, 0);
    add(0, 1, 1, 0, 0, 0, 0, 24'h0, 24'h223456, 0, 0, 1);
    add(0, 1, 0, 0, 0, 0, 0, 24'h0, 24'h223456, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 24'h0, 24'h223456, 0, 1, 0);   // commit clears dirty
    add(0, 0, 0, 0, 0, 0, 0, 24'h0, 24'h223456, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 24'h0, 24'h223456, 0, 0, 0);
    add(1, 1, 1, 0, 0, 0, 0, 24'h0, 24'h000001, 0, 0, 0);   // button held through reset
    add(0, 1, 1, 0, 0, 0, 0, 24'h0, 24'h100001, 0, 0, 1);
    add(0, 1, 1, 0, 0, 0, 0, 24'h0, 24'h100001, 0, 0, 1);
    add(1, 1, 1, 0, 0, 0, 0, 24'h0, 24'h000001, 0, 0, 0);   // reset mid-repeat
    add(0, 1, 1, 0, 0, 0, 0, 24'h0, 24'h100001, 0, 0, 1);
    add(0, 1, 0, 0, 0, 0, 0, 24'h0, 24'h100001, 0, 0, 1);
    add(1, 0, 0, 0, 0, 0, 0, 24'h0, 24'h000001, 0, 0, 0);   // reset suppresses commit
    add(0, 0, 0, 0, 0, 0, 0, 24'h0, 24'h000001, 0, 0, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].en, vecs[i].up, vecs[i].dn, vecs[i].l, vecs[i].r,
            vecs[i].ld, vecs[i].ldv);
      check("table", i, vecs[i].ev, vecs[i].ec, vecs[i].ecm, vecs[i].ed);
    end

    // ---------------- random stimulus vs model ----------------
    r_en = 1; r_up = 0; r_dn = 0; r_l = 0; r_r = 0;
    for (int c = 0; c < 3000; c++) begin
      r_rst = (c == 0) || ($urandom_range(0, 799) == 0);
      if (r_en) r_en = ($urandom_range(0, 99) != 0);
      else      r_en = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 14) == 0) r_up = ~r_up;
      if ($urandom_range(0, 14) == 0) r_dn = ~r_dn;
      if ($urandom_range(0, 5) == 0)  r_l  = ~r_l;
      if ($urandom_range(0, 5) == 0)  r_r  = ~r_r;
      r_ld  = ($urandom_range(0, 59) == 0);
      r_ldv = rand_valid();
      model_cycle(r_rst, r_en, r_up, r_dn, r_l, r_r, r_ld, r_ldv);
      exp_q.push_back({m_value(), 3'(m_cur), m_commit, m_dirty});
      drive(r_rst, r_en, r_up, r_dn, r_l, r_r, r_ld, r_ldv);
      e = exp_q.pop_front();
      check("rand", c, e[28:5], e[4:2], e[1], e[0]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
